trace_feeder: RTL and testbench

//  Source end of the cache trace interface: accepts trace records (op, address) from a loader

---
 rtl/trace_feeder.sv | 180 ++++++++++++++++++
 tb/tb_trace_feeder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_feeder.sv
`default_nettype none
// ============================================================================
// trace_feeder : buffers loader trace records and issues them to the cache
//                model one access per slot, with gap pacing and stall hold.
// Rev 1.0
// ============================================================================
module trace_feeder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  input  logic              stall,
  output logic              acc_valid,
  output logic [1:0]        Access_type,
  output logic [ADDR_W-1:0] Hex_address,
  output logic              done,
  output logic              err_op,
  output logic [31:0]       cnt_read,
  output logic [31:0]       cnt_write,
  output logic [31:0]       cnt_inval
);
  localparam int            AW         = $clog2(DEPTH);
  localparam logic [7:0]    GAP_LOAD   = 8'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] IDX_ONE    = AW'(1);
  localparam logic [1:0]    OP_READ    = 2'd0;
  localparam logic [1:0]    OP_WRITE   = 2'd1;
  localparam logic [1:0]    OP_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mem_op_q   [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DEPTH-1:0]  mem_last_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [7:0]        gap_q, gap_d;
  logic              acc_valid_q, last_q, last_seen_q, err_q;
  logic [1:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       cnt_rd_q, cnt_wr_q, cnt_iv_q;

  logic [AW-1:0]     w_wr_idx, w_rd_idx, w_prev_idx;
  logic              w_full, w_empty, w_accept, w_push, w_drop;
  logic              w_mark, w_term, w_avail, w_head_last, w_issue;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_wr_idx   = wr_ptr_q[AW-1:0];
  assign w_rd_idx   = rd_ptr_q[AW-1:0];
  assign w_prev_idx = w_wr_idx - IDX_ONE;
  assign w_empty    = (wr_ptr_q == rd_ptr_q);
  assign w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (w_wr_idx == w_rd_idx);
  assign done       = (state_q == S_DONE);
  assign in_ready   = rst_n && !w_full && !done && !last_seen_q;
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && (in_op != OP_ILLEGAL);
  assign w_drop     = w_accept && (in_op == OP_ILLEGAL);
  // A dropped final record hands its last flag to the newest buffered entry,
  // or ends the trace outright when nothing is left to issue.
  assign w_mark     = w_drop && in_last && !w_empty;
  assign w_term     = w_drop && in_last && w_empty;
  assign w_avail    = !w_empty && !stall;
  assign w_head_last = mem_last_q[w_rd_idx] || (w_mark && (w_rd_idx == w_prev_idx));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    w_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_avail) begin
          state_d = S_ISSUE;
          w_issue = 1'b1;
        end
      end
      S_ISSUE: begin
        if (last_q) begin
          state_d = S_DONE;
        end else if (GAP > 0) begin
          state_d = S_WAIT;
          gap_d   = GAP_LOAD;
        end else if (w_avail) begin
          state_d = S_ISSUE;
          w_issue = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (w_avail) begin
          state_d = S_ISSUE;
          w_issue = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (w_term) begin
      state_d = S_DONE;
      w_issue = 1'b0;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_op_q[w_wr_idx]   <= in_op;
      mem_addr_q[w_wr_idx] <= in_addr;
      mem_last_q[w_wr_idx] <= in_last;
    end
    if (w_mark) begin
      mem_last_q[w_prev_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_valid_q <= 1'b0;
      last_q      <= 1'b0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
      type_q      <= 2'd0;
      addr_q      <= '0;
      cnt_rd_q    <= 32'd0;
      cnt_wr_q    <= 32'd0;
      cnt_iv_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      acc_valid_q <= w_issue;
      if (w_push)              wr_ptr_q    <= wr_ptr_q + PTR_ONE;
      if (w_accept && in_last) last_seen_q <= 1'b1;
      if (w_drop)              err_q       <= 1'b1;
      if (w_issue) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        type_q   <= mem_op_q[w_rd_idx];
        addr_q   <= mem_addr_q[w_rd_idx];
        last_q   <= w_head_last;
        case (mem_op_q[w_rd_idx])
          OP_READ:  cnt_rd_q <= sat_inc(cnt_rd_q);
          OP_WRITE: cnt_wr_q <= sat_inc(cnt_wr_q);
          default:  cnt_iv_q <= sat_inc(cnt_iv_q);
        endcase
      end
    end
  end

  assign acc_valid   = acc_valid_q;
  assign Access_type = type_q;
  assign Hex_address = addr_q;
  assign err_op      = err_q;
  assign cnt_read    = cnt_rd_q;
  assign cnt_write   = cnt_wr_q;
  assign cnt_inval   = cnt_iv_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_feeder.sv
`default_nettype none
// tb_trace_feeder : vector table, directed corner sequences and a randomized
// run scored against a queue-based reference of the issued stream.
module tb_trace_feeder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_last, stall;
  logic [1:0]  in_op;
  logic [31:0] in_addr;
  logic        rdy0, acc0, dn0, err0, rdy3, acc3, dn3, err3;
  logic [1:0]  ty0, ty3;
  logic [31:0] ha0, cr0, cw0, ci0, ha3, cr3, cw3, ci3;

  trace_feeder #(.DEPTH(DEPTH), .ADDR_W(32), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_op(in_op),
    .in_addr(in_addr), .in_last(in_last), .stall(stall), .acc_valid(acc0),
    .Access_type(ty0), .Hex_address(ha0), .done(dn0), .err_op(err0),
    .cnt_read(cr0), .cnt_write(cw0), .cnt_inval(ci0));

  trace_feeder #(.DEPTH(DEPTH), .ADDR_W(32), .GAP(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .in_op(in_op),
    .in_addr(in_addr), .in_last(in_last), .stall(stall), .acc_valid(acc3),
    .Access_type(ty3), .Hex_address(ha3), .done(dn3), .err_op(err3),
    .cnt_read(cr3), .cnt_write(cw3), .cnt_inval(ci3));

  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [33:0] strobes[$];
  logic [33:0] sent[$];
  int          gap_cyc[$];

  typedef struct {
    logic v; logic [1:0] op; logic [31:0] a; logic l;
    logic rdy; logic acc; logic [1:0] ty; logic [31:0] ha; logic dn;
  } vec_t;
  vec_t tbl[7];

  // reference-model state for the randomized run
  logic [33:0] mq[$];
  logic [33:0] h;
  bit          ls_m, err_m, prev_st, sent_last, exp_rdy;
  int          m_rd, m_wr, m_iv, rc, k;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (acc0) strobes.push_back({ty0, ha0});
    if (acc3) gap_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_addr = 32'd0; in_last = 1'b0; stall = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", rdy0, 0);
    chk("rst_acc_valid", acc0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_err_op", err0, 0);
    chk("rst_counters", {cr0 | cw0 | ci0}, 0);
    chk("rst_type_addr", {ty0, ha0}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    strobes.delete(); sent.delete(); gap_cyc.delete();
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic l);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_addr = a; in_last = l;
    @(negedge clk);
    while (!rdy0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", (n < 100), 1);
    if (op != 2'd3) sent.push_back({op, a});
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!dn0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, dn0, 1);
    step();
  endtask

  task automatic compare_stream(input string name);
    chk({name, "_len"}, strobes.size(), sent.size());
    for (int i = 0; i < strobes.size() && i < sent.size(); i++)
      chk({name, "_order"}, strobes[i], sent[i]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // T1: cycle-accurate table for three consecutive accesses
    tbl[0] = '{1'b1, 2'd0, 32'h1040, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,    1'b0};
    tbl[1] = '{1'b1, 2'd1, 32'h1040, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,    1'b0};
    tbl[2] = '{1'b1, 2'd2, 32'h1040, 1'b1, 1'b1, 1'b1, 2'd0, 32'h1040, 1'b0};
    tbl[3] = '{1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b1, 2'd1, 32'h1040, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b1, 2'd2, 32'h1040, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b0, 2'd2, 32'h1040, 1'b1};
    tbl[6] = '{1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b0, 2'd2, 32'h1040, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].v; in_op = tbl[i].op; in_addr = tbl[i].a; in_last = tbl[i].l;
      @(negedge clk);
      chk("t1_in_ready", rdy0, tbl[i].rdy);
      chk("t1_acc_valid", acc0, tbl[i].acc);
      chk("t1_type", ty0, tbl[i].ty);
      chk("t1_addr", ha0, tbl[i].ha);
      chk("t1_done", dn0, tbl[i].dn);
      step();
    end
    in_valid = 1'b0;
    chk("t1_cnt_read", cr0, 1);
    chk("t1_cnt_write", cw0, 1);
    chk("t1_cnt_inval", ci0, 1);

    // T2: GAP=3 spaces strobes four cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd0, 32'h400 + 32'(i * 4), 1'b0);
    repeat (30) step();
    chk("t2_strobe_count", gap_cyc.size(), 4);
    for (int i = 1; i < gap_cyc.size(); i++) chk("t2_spacing", gap_cyc[i] - gap_cyc[i-1], 4);
    chk("t2_cnt_read", cr3, 4);

    // T3: fill under stall, overflow attempt, then drain in order
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(2'(i % 3), 32'h3000 + 32'(i * 4), 1'b0);
    in_valid = 1'b1; in_op = 2'd0; in_addr = 32'h3000 + 32'(DEPTH * 4); in_last = 1'b0;
    @(negedge clk);
    chk("t3_full_ready", rdy0, 0);
    chk("t3_stall_holds", acc0, 0);
    step();
    @(negedge clk);
    chk("t3_full_ready2", rdy0, 0);
    step();
    stall = 1'b0; in_valid = 1'b0;
    push(2'd0, 32'h3000 + 32'(DEPTH * 4), 1'b0);
    push(2'd1, 32'h3000 + 32'((DEPTH + 1) * 4), 1'b1);
    wait_done("t3_done");
    compare_stream("t3");

    // T4: illegal op dropped between reads
    do_reset();
    push(2'd0, 32'h100, 1'b0);
    push(2'd3, 32'h2000, 1'b0);
    push(2'd0, 32'h104, 1'b1);
    wait_done("t4_done");
    chk("t4_err_op", err0, 1);
    chk("t4_cnt_read", cr0, 2);
    compare_stream("t4");

    // T4b: illegal final record marks the buffered tail as last
    do_reset();
    stall = 1'b1;
    push(2'd0, 32'h200, 1'b0);
    push(2'd1, 32'h204, 1'b0);
    push(2'd3, 32'h208, 1'b1);
    stall = 1'b0;
    wait_done("t4b_done");
    chk("t4b_err_op", err0, 1);
    compare_stream("t4b");

    // T4c: illegal final record into an empty FIFO ends the trace next cycle
    do_reset();
    push(2'd1, 32'h300, 1'b0);
    repeat (4) step();
    chk("t4c_not_done", dn0, 0);
    push(2'd3, 32'h304, 1'b1);
    @(negedge clk);
    chk("t4c_done_next", dn0, 1);
    compare_stream("t4c");
    step();

    // T5: reset after two issues discards the rest
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) push(2'd0, 32'h500 + 32'(i * 4), 1'b0);
    stall = 1'b0;
    k = 0; rc = 0;
    while (k < 2 && rc < 50) begin
      @(negedge clk);
      if (acc0) k++;
      rc++;
    end
    chk("t5_two_issues", k, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", rdy0, 1);
    chk("t5_counters", {cr0 | cw0 | ci0}, 0);
    chk("t5_done", dn0, 0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (acc0) k++;
      @(negedge clk);
    end
    chk("t5_no_strobes", k, 0);
    step();

    // T6: simultaneous push/pop at DEPTH-1 occupancy
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) push(2'(i % 3), 32'h600 + 32'(i * 4), 1'b0);
    stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_op = 2'((i + 1) % 3); in_addr = 32'h700 + 32'(i * 4); in_last = 1'b0;
      @(negedge clk);
      chk("t6_ready", rdy0, 1);
      if (i > 0) chk("t6_back_to_back", acc0, 1);
      if (rdy0) sent.push_back({in_op, in_addr});
      step();
    end
    in_valid = 1'b0;
    push(2'd0, 32'h800, 1'b1);
    wait_done("t6_done");
    compare_stream("t6");

    // Randomized run against the reference queue
    do_reset();
    mq.delete();
    ls_m = 0; err_m = 0; prev_st = 0; sent_last = 0;
    m_rd = 0; m_wr = 0; m_iv = 0; rc = 0;
    while (!(dn0 === 1'b1 && sent_last) && rc < 3000) begin
      stall    = ($urandom_range(0, 9) < 3);
      in_valid = !sent_last && ($urandom_range(0, 2) != 0);
      in_op    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_addr  = $urandom;
      in_last  = (rc >= 300);
      @(negedge clk);
      if (acc0) begin
        chk("rnd_stall_honoured", prev_st, 0);
        chk("rnd_strobe_expected", (mq.size() != 0), 1);
        if (mq.size() != 0) begin
          h = mq.pop_front();
          chk("rnd_stream", {ty0, ha0}, h);
          if (h[33:32] == 2'd0) m_rd++;
          else if (h[33:32] == 2'd1) m_wr++;
          else m_iv++;
        end
      end
      exp_rdy = (mq.size() < DEPTH) && !ls_m;
      chk("rnd_in_ready", rdy0, exp_rdy);
      if (dn0) chk("rnd_done_drained", mq.size(), 0);
      if (in_valid && exp_rdy) begin
        if (in_op == 2'd3) err_m = 1;
        else mq.push_back({in_op, in_addr});
        if (in_last) begin
          ls_m = 1;
          sent_last = 1;
        end
      end
      prev_st = stall;
      step();
      rc++;
    end
    in_valid = 1'b0;
    chk("rnd_done", dn0, 1);
    chk("rnd_leftover", mq.size(), 0);
    chk("rnd_cnt_read", cr0, m_rd);
    chk("rnd_cnt_write", cw0, m_wr);
    chk("rnd_cnt_inval", ci0, m_iv);
    chk("rnd_err_op", err0, err_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
